// File: rtl/mem_arbiter_pkg.sv
// Shared defaults for the memory arbiter and a round-robin slot helper.
package mem_arbiter_pkg;

  localparam int def_num_cu          = 4;
  localparam int def_num_cu_log      = 2;
  localparam int def_memory_size_log = 10;
  localparam int def_data_width      = 32;
  localparam int def_max_hold        = 64;

  function automatic int rr_slot(input int last, input int step, input int n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester after i_Last, wrapping around.
module mem_arbiter_rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int num_cu     = def_num_cu,
  parameter int num_cu_log = def_num_cu_log
) (
  input  logic [num_cu-1:0]     i_Request,
  input  logic [num_cu_log-1:0] i_Last,
  output logic                  o_Valid,
  output logic [num_cu_log-1:0] o_Index
);

  int slot;

  always_comb begin
    o_Valid = 1'b0;
    o_Index = '0;
    slot    = 0;
    // i_Last itself is scanned last, so the CU that just released has lowest priority
    for (int i = 1; i <= num_cu; i++) begin
      slot = rr_slot(int'(i_Last), i, num_cu);
      if (!o_Valid && i_Request[slot]) begin
        o_Valid = 1'b1;
        o_Index = slot[num_cu_log-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the shared memory port; grant held for the owner's whole burst.
// Optional hold-overrun flag enabled by MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int num_cu          = def_num_cu,
  parameter int num_cu_log      = def_num_cu_log,
  parameter int memory_size_log = def_memory_size_log,
  parameter int data_width      = def_data_width,
  parameter int max_hold        = def_max_hold
) (
  input  logic                            i_Clock,
  input  logic                            i_Reset,
  input  logic [num_cu-1:0]               i_Grant_Request,
  output logic [num_cu-1:0]               o_Grant,
  input  logic [num_cu*memory_size_log-1:0] i_CU_Memory_Address,
  input  logic [num_cu-1:0]               i_CU_Memory_Write_Enable,
  input  logic [num_cu-1:0]               i_CU_Memory_Read_Enable,
  input  logic [num_cu*data_width-1:0]    i_CU_Write_Data,
  output logic [memory_size_log-1:0]      o_Memory_Address,
  output logic                            o_Memory_Write_Enable,
  output logic                            o_Memory_Read_Enable,
  output logic [data_width-1:0]           o_Memory_Write_Data,
  output logic [num_cu_log-1:0]           o_Owner,
  output logic                            o_Busy,
  output logic                            o_Timeout
);

  typedef enum logic [1:0] {
    s_Idle    = 2'd0,
    s_Granted = 2'd1,
    s_Release = 2'd2
  } state_t;

  state_t                state;
  logic [num_cu_log-1:0] r_Last;
  logic                  pick_valid;
  logic [num_cu_log-1:0] pick_index;
  logic [num_cu-1:0]     pick_onehot;

  mem_arbiter_rr_picker #(
    .num_cu    (num_cu),
    .num_cu_log(num_cu_log)
  ) u_picker (
    .i_Request(i_Grant_Request),
    .i_Last   (r_Last),
    .o_Valid  (pick_valid),
    .o_Index  (pick_index)
  );

  always_comb begin
    pick_onehot             = '0;
    pick_onehot[pick_index] = 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      state   <= s_Idle;
      o_Grant <= '0;
      o_Owner <= '0;
      o_Busy  <= 1'b0;
      r_Last  <= num_cu_log'(num_cu - 1);
    end else begin
      case (state)
        s_Idle: begin
          if (pick_valid) begin
            o_Grant <= pick_onehot;
            o_Owner <= pick_index;
            o_Busy  <= 1'b1;
            state   <= s_Granted;
          end
        end
        s_Granted: begin
          // only the owner's request matters until it lets go
          if (!i_Grant_Request[o_Owner]) begin
            o_Grant <= '0;
            o_Busy  <= 1'b0;
            r_Last  <= o_Owner;
            state   <= s_Release;
          end
        end
        s_Release: state <= s_Idle;
        default:   state <= s_Idle;
      endcase
    end
  end

  always_comb begin
    o_Memory_Address      = '0;
    o_Memory_Write_Enable = 1'b0;
    o_Memory_Read_Enable  = 1'b0;
    o_Memory_Write_Data   = '0;
    if (state == s_Granted) begin
      o_Memory_Address      = i_CU_Memory_Address[int'(o_Owner)*memory_size_log +: memory_size_log];
      o_Memory_Write_Enable = i_CU_Memory_Write_Enable[o_Owner];
      // write wins if the owner raises both enables
      o_Memory_Read_Enable  = i_CU_Memory_Read_Enable[o_Owner] & ~i_CU_Memory_Write_Enable[o_Owner];
      o_Memory_Write_Data   = i_CU_Write_Data[int'(o_Owner)*data_width +: data_width];
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int hold_w = $clog2(max_hold + 1);

  logic [hold_w-1:0] hold_cnt;

  // flag rises on the edge where the count reaches max_hold; grant is left alone
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      hold_cnt  <= '0;
      o_Timeout <= 1'b0;
    end else if (state == s_Idle && pick_valid) begin
      hold_cnt <= '0;
    end else if (state == s_Granted && hold_cnt != hold_w'(max_hold)) begin
      hold_cnt <= hold_cnt + hold_w'(1);
      if (hold_cnt == hold_w'(max_hold - 1)) begin
        o_Timeout <= 1'b1;
      end
    end
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = ^max_hold;
  assign o_Timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a grant-order scoreboard.
module tb_mem_arbiter;

  localparam int N        = 4;
  localparam int NL       = 2;
  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  we;
  logic [N-1:0]  re;
  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] wd_a   [N];
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] wd_bus;

  logic [N-1:0]  grant;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_wd;
  logic [NL-1:0] owner;
  logic          busy;
  logic          timeout;

  always_comb begin
    addr_bus = '0;
    wd_bus   = '0;
    for (int n = 0; n < N; n++) begin
      addr_bus[n*AW +: AW] = addr_a[n];
      wd_bus[n*DW +: DW]   = wd_a[n];
    end
  end

  mem_arbiter #(
    .num_cu(N), .num_cu_log(NL), .memory_size_log(AW), .data_width(DW), .max_hold(MAX_HOLD)
  ) dut (
    .i_Clock                 (clk),
    .i_Reset                 (rst),
    .i_Grant_Request         (req),
    .o_Grant                 (grant),
    .i_CU_Memory_Address     (addr_bus),
    .i_CU_Memory_Write_Enable(we),
    .i_CU_Memory_Read_Enable (re),
    .i_CU_Write_Data         (wd_bus),
    .o_Memory_Address        (mem_addr),
    .o_Memory_Write_Enable   (mem_we),
    .o_Memory_Read_Enable    (mem_re),
    .o_Memory_Write_Data     (mem_wd),
    .o_Owner                 (owner),
    .o_Busy                  (busy),
    .o_Timeout               (timeout)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_addr"},  32'(mem_addr), 32'h0);
    check({tag, "_we"},    32'(mem_we), 32'h0);
    check({tag, "_re"},    32'(mem_re), 32'h0);
    check({tag, "_wd"},    mem_wd, 32'h0);
  endtask

  // pop the next expected owner when the DUT shows a grant
  task automatic expect_grant(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_grant"}, 32'(grant), 32'h0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_grant"}, 32'(grant), 32'(1) << e);
      check({tag, "_owner"}, 32'(owner), 32'(e));
      check({tag, "_busy"},  32'(busy), 32'h1);
      check({tag, "_addr"},  32'(mem_addr), 32'(addr_a[e]));
      check({tag, "_wd"},    mem_wd, wd_a[e]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  prev_g, zeros, seen, age, cur;
    bit  done;

    rst = 1'b0;
    req = '1;
    we  = '1;
    re  = '1;
    for (int n = 0; n < N; n++) begin
      addr_a[n] = AW'(10'h100 + n);
      wd_a[n]   = DW'(32'hA0 + n);
    end

    // reset held with every CU requesting
    tick();
    tick();
    check_idle("reset");
    check("reset_timeout", 32'(timeout), 32'h0);

    rst = 1'b1;
    req = '0;
    tick();
    check_idle("post_reset");

    // lone CU2 write burst
    addr_a[2] = 10'h155;
    we[2]     = 1'b1;
    re[2]     = 1'b0;
    wd_a[2]   = 32'hCAFE_0002;
    req       = 4'b0100;
    exp_q.push_back(2);
    tick();
    expect_grant("cu2");
    check("cu2_we", 32'(mem_we), 32'h1);
    check("cu2_re", 32'(mem_re), 32'h0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("cu2_hold", 32'(grant), 32'h4);
    end
    req = '0;
    tick();
    check_idle("cu2_drop");
    tick();
    check_idle("cu2_turnaround");

    // round robin from a fresh reset: expected order 0,1,2,3,0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = '1;
    exp_q = {0, 1, 2, 3, 0};
    prev_g = 0; zeros = 0; seen = 0; age = 0; cur = 0; done = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      tick();
      if (grant != '0) begin
        if (prev_g == 0) begin
          if (seen > 0) check("rr_gap", 32'(zeros), 32'd2);
          cur = int'(owner);
          expect_grant("rr");
          seen++;
          age = 0;
        end else begin
          age++;
        end
        zeros = 0;
        if (age == 3) begin
          req[cur] = 1'b0;
          if (seen == 5) done = 1'b1;
        end
      end else begin
        zeros++;
        if (prev_g != 0) req[cur] = 1'b1;
      end
      prev_g = int'(grant);
    end
    check("rr_grants_seen", 32'(seen), 32'd5);
    req = '0;
    tick();
    tick();
    tick();
    check_idle("rr_end");

    // CU1 owns while CU3 drives its own enables
    addr_a[1] = 10'h0AA; we[1] = 1'b1; re[1] = 1'b0; wd_a[1] = 32'h1111_0001;
    addr_a[3] = 10'h3FF; we[3] = 1'b1; re[3] = 1'b1; wd_a[3] = 32'h3333_0003;
    req = 4'b1010;
    exp_q.push_back(1);
    tick();
    expect_grant("cu1");
    check("cu1_we", 32'(mem_we), 32'h1);
    check("cu1_re", 32'(mem_re), 32'h0);
    re[1] = 1'b1;
    tick();
    check("both_we", 32'(mem_we), 32'h1);
    check("both_re", 32'(mem_re), 32'h0);
    we[1] = 1'b0;
    tick();
    check("rd_only_we", 32'(mem_we), 32'h0);
    check("rd_only_re", 32'(mem_re), 32'h1);
    check("rd_only_addr", 32'(mem_addr), 32'h0AA);
    req[1] = 1'b0;
    exp_q.push_back(3);
    tick();
    check_idle("cu1_rel");
    tick();
    check_idle("cu1_turn");
    tick();
    expect_grant("cu3");
    check("cu3_we", 32'(mem_we), 32'h1);
    req = '0;
    tick();
    tick();
    tick();

    // reset while CU0 reads
    addr_a[0] = 10'h012; we[0] = 1'b0; re[0] = 1'b1; wd_a[0] = 32'h0;
    req = 4'b0001;
    exp_q.push_back(0);
    tick();
    expect_grant("cu0");
    check("cu0_re", 32'(mem_re), 32'h1);
    rst = 1'b0;
    tick();
    check_idle("rst_mid");
    check("rst_mid_owner", 32'(owner), 32'h0);
    rst = 1'b1;
    req = 4'b0011;
    exp_q.push_back(0);
    tick();
    expect_grant("post_rst");

    // long hold by CU0: grant kept, overrun flag depends on build
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("hold_grant", 32'(grant), 32'h1);
`ifdef MEM_ARB_TIMEOUT_EN
      check("hold_timeout", 32'(timeout), (k >= MAX_HOLD) ? 32'h1 : 32'h0);
`else
      check("hold_timeout", 32'(timeout), 32'h0);
`endif
    end
    req = '0;
    tick();
    check_idle("hold_rel");
`ifdef MEM_ARB_TIMEOUT_EN
    check("timeout_sticky", 32'(timeout), 32'h1);
`else
    check("timeout_sticky", 32'(timeout), 32'h0);
`endif
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
